// File: rtl/framebuffer_store_pkg.sv
// Shared framebuffer geometry, RGB565 field positions, store FSM states and the
// pixel-to-RAM address mapping used by both the fetch and store sides.
package framebuffer_store_pkg;

    localparam int unsigned COLUMN_BITS_DEFAULT = 6;
    localparam int unsigned ROW_BITS_DEFAULT    = 4;
    localparam int unsigned AW_DEFAULT          = 1 + ROW_BITS_DEFAULT + COLUMN_BITS_DEFAULT;

    localparam int unsigned RGB565_R_MSB = 15;
    localparam int unsigned RGB565_R_LSB = 11;
    localparam int unsigned RGB565_G_MSB = 10;
    localparam int unsigned RGB565_G_LSB = 5;
    localparam int unsigned RGB565_B_MSB = 4;
    localparam int unsigned RGB565_B_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FIRST,
        ST_SECOND,
        ST_WRITE
    } store_state_t;

    function automatic int unsigned address_width(input int unsigned column_bits,
                                                  input int unsigned row_bits);
        return 1 + row_bits + column_bits;
    endfunction

    // Raster index {y, x} maps to {half, row, ~x}; y already equals {half, row},
    // so the mapping reduces to inverting the column field.
    function automatic logic [31:0] fb_address(input logic [31:0] pixel,
                                               input int unsigned column_bits);
        logic [31:0] col_mask;
        col_mask = (32'd1 << column_bits) - 32'd1;
        return pixel ^ col_mask;
    endfunction

endpackage

// File: rtl/framebuffer_byte_packer.sv
// Packs two consecutive stream bytes into one RGB565 word; byte order set by
// HIGH_BYTE_FIRST. word_valid accompanies the second byte.
module framebuffer_byte_packer #(
    parameter int unsigned HIGH_BYTE_FIRST = 1
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    input  logic        load_first,
    input  logic        load_second,
    output logic [15:0] word_out,
    output logic        word_valid
);

    logic [7:0] first_q;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            first_q <= '0;
        end else if (clear) begin
            first_q <= '0;
        end else if (load_first) begin
            first_q <= byte_in;
        end
    end

    assign word_out   = (HIGH_BYTE_FIRST != 0) ? {first_q, byte_in} : {byte_in, first_q};
    assign word_valid = load_second;

endmodule

// File: rtl/framebuffer_store.sv
// Write side of the dual-half framebuffer: packs the RGB565 byte stream into pixels
// and writes each to {half, row, ~column}, one frame per frame_start.
module framebuffer_store
    import framebuffer_store_pkg::*;
#(
    parameter int unsigned COLUMN_BITS     = COLUMN_BITS_DEFAULT,
    parameter int unsigned ROW_BITS        = ROW_BITS_DEFAULT,
    parameter int unsigned HIGH_BYTE_FIRST = 1,
    localparam int unsigned AW             = address_width(COLUMN_BITS, ROW_BITS)
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic          frame_start,
    input  logic [7:0]    byte_in,
    input  logic          byte_valid,
    output logic          byte_ready,
    output logic [AW-1:0] ram_address,
    output logic [15:0]   ram_data_out,
    output logic          ram_write_enable,
    output logic          ram_clk_enable,
    output logic          ram_reset,
    output logic          frame_done,
    output logic          overrun
);

    store_state_t  state, state_next;
    logic [AW-1:0] pixel_index;
    logic          load_first, load_second;
    logic [15:0]   packed_word;
    logic          packed_valid;
    logic          last_pixel;
    logic          overrun_set;

    framebuffer_byte_packer #(
        .HIGH_BYTE_FIRST(HIGH_BYTE_FIRST)
    ) u_packer (
        .clk_in     (clk_in),
        .reset      (reset),
        .clear      (frame_start),
        .byte_in    (byte_in),
        .load_first (load_first),
        .load_second(load_second),
        .word_out   (packed_word),
        .word_valid (packed_valid)
    );

    assign last_pixel       = (pixel_index == '1);
    assign ram_write_enable = (state == ST_WRITE);
    assign ram_clk_enable   = ram_write_enable;
    assign ram_reset        = reset;
    assign overrun_set      = (state != ST_IDLE) && byte_valid && !byte_ready && !frame_start;

    always_comb begin
        state_next  = state;
        byte_ready  = 1'b0;
        load_first  = 1'b0;
        load_second = 1'b0;
        case (state)
            ST_IDLE: ;
            ST_FIRST: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    load_first = 1'b1;
                    state_next = ST_SECOND;
                end
            end
            ST_SECOND: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    load_second = 1'b1;
                    state_next  = ST_WRITE;
                end
            end
            ST_WRITE: state_next = last_pixel ? ST_IDLE : ST_FIRST;
            default:  state_next = ST_IDLE;
        endcase
        // frame_start wins over any byte offered in the same cycle
        if (frame_start) begin
            state_next  = ST_FIRST;
            load_first  = 1'b0;
            load_second = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            pixel_index  <= '0;
            ram_address  <= '0;
            ram_data_out <= '0;
            frame_done   <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state      <= state_next;
            frame_done <= (state == ST_WRITE) && last_pixel;
            if (packed_valid) begin
                ram_data_out <= packed_word;
                ram_address  <= AW'(fb_address(32'(pixel_index), COLUMN_BITS));
            end
            if (frame_start) begin
                pixel_index <= '0;
                overrun     <= 1'b0;
            end else begin
                if (state == ST_WRITE) begin
                    pixel_index <= last_pixel ? '0 : pixel_index + 1'b1;
                end
                if (overrun_set) begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_framebuffer_store.sv
// Directed self-checking bench for framebuffer_store; a second instance covers
// low-byte-first packing on the same stimulus.
module tb_framebuffer_store;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        frame_start;
    logic [7:0]  byte_in;
    logic        byte_valid;

    logic        byte_ready, ram_write_enable, ram_clk_enable, ram_reset, frame_done, overrun;
    logic [10:0] ram_address;
    logic [15:0] ram_data_out;

    logic        b_byte_ready, b_ram_write_enable, b_ram_clk_enable, b_ram_reset, b_frame_done, b_overrun;
    logic [10:0] b_ram_address;
    logic [15:0] b_ram_data_out;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;

    int unsigned wr_count    = 0;
    int unsigned b_wr_count  = 0;
    int unsigned done_count  = 0;
    int unsigned long_strobe = 0;
    logic        prev_we     = 1'b0;
    logic [15:0] mem [2048];

    always #5 clk_in = ~clk_in;

    framebuffer_store #(
        .COLUMN_BITS(6),
        .ROW_BITS(4),
        .HIGH_BYTE_FIRST(1)
    ) dut (
        .clk_in          (clk_in),
        .reset           (reset),
        .frame_start     (frame_start),
        .byte_in         (byte_in),
        .byte_valid      (byte_valid),
        .byte_ready      (byte_ready),
        .ram_address     (ram_address),
        .ram_data_out    (ram_data_out),
        .ram_write_enable(ram_write_enable),
        .ram_clk_enable  (ram_clk_enable),
        .ram_reset       (ram_reset),
        .frame_done      (frame_done),
        .overrun         (overrun)
    );

    framebuffer_store #(
        .COLUMN_BITS(6),
        .ROW_BITS(4),
        .HIGH_BYTE_FIRST(0)
    ) dut_lo (
        .clk_in          (clk_in),
        .reset           (reset),
        .frame_start     (frame_start),
        .byte_in         (byte_in),
        .byte_valid      (byte_valid),
        .byte_ready      (b_byte_ready),
        .ram_address     (b_ram_address),
        .ram_data_out    (b_ram_data_out),
        .ram_write_enable(b_ram_write_enable),
        .ram_clk_enable  (b_ram_clk_enable),
        .ram_reset       (b_ram_reset),
        .frame_done      (b_frame_done),
        .overrun         (b_overrun)
    );

    always @(negedge clk_in) begin
        if (ram_write_enable) begin
            wr_count          <= wr_count + 1;
            mem[ram_address]  <= ram_data_out;
        end
        if (b_ram_write_enable) b_wr_count <= b_wr_count + 1;
        if (ram_write_enable && prev_we) long_strobe <= long_strobe + 1;
        if (ram_write_enable !== ram_clk_enable) long_strobe <= long_strobe + 100;
        prev_we <= ram_write_enable;
        if (frame_done) done_count <= done_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk_in);
        byte_in = b;
        while (!byte_ready && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        check("send_ready_wait", 32'(n < 50), 32'd1);
        byte_valid = 1'b1;
        @(posedge clk_in);
        #1 byte_valid = 1'b0;
    endtask

    task automatic pulse_frame_start();
        @(negedge clk_in);
        frame_start = 1'b1;
        @(negedge clk_in);
        frame_start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base_wr, base_done, base_b;

        reset = 1'b1; frame_start = 1'b0; byte_in = '0; byte_valid = 1'b0;
        repeat (3) @(negedge clk_in);
        check("rst_ready",   byte_ready,       0);
        check("rst_addr",    ram_address,      0);
        check("rst_data",    ram_data_out,     0);
        check("rst_we",      ram_write_enable, 0);
        check("rst_ce",      ram_clk_enable,   0);
        check("rst_done",    frame_done,       0);
        check("rst_overrun", overrun,          0);
        check("rst_passthru", ram_reset,       1);
        reset = 1'b0;
        @(negedge clk_in);
        check("ram_reset_low", ram_reset, 0);

        // 1: single pixel
        pulse_frame_start();
        send_byte(8'hF8);
        send_byte(8'h00);
        @(negedge clk_in);
        check("t1_we",   ram_write_enable, 1);
        check("t1_ce",   ram_clk_enable,   1);
        check("t1_addr", ram_address,      11'h03F);
        check("t1_data", ram_data_out,     16'hF800);
        @(negedge clk_in);
        check("t1_we_off",   ram_write_enable, 0);
        check("t1_data_hold", ram_data_out,    16'hF800);
        check("t1_addr_hold", ram_address,     11'h03F);

        // 2: full frame, pixel k = k
        base_wr = wr_count; base_done = done_count;
        pulse_frame_start();
        for (int k = 0; k < 2048; k++) begin
            send_byte(8'(k >> 8));
            send_byte(8'(k & 255));
        end
        repeat (4) @(negedge clk_in);
        check("t2_writes",   wr_count - base_wr,     2048);
        check("t2_done",     done_count - base_done, 1);
        check("t2_pix0",     mem[11'h03F], 16'd0);
        check("t2_pix64",    mem[11'h07F], 16'd64);
        check("t2_pix1024",  mem[11'h43F], 16'd1024);
        check("t2_pix2047",  mem[11'h7C0], 16'd2047);
        check("t2_idle",     byte_ready,   0);
        check("t2_overrun",  overrun,      0);
        check("t2_done_low", frame_done,   0);

        // 3: byte_valid held high
        pulse_frame_start();
        for (int i = 0; i < 9; i++) begin
            byte_in = 8'(8'h10 + i);
            byte_valid = 1'b1;
            check("t3_ready",   byte_ready,       32'(i % 3 != 2));
            check("t3_we",      ram_write_enable, 32'(i % 3 == 2));
            check("t3_overrun", overrun,          32'(i >= 3));
            if (i % 3 == 2) begin
                check("t3_data", ram_data_out, {16'd0, 8'(8'h10 + i - 2), 8'(8'h10 + i - 1)});
                check("t3_addr", ram_address,  32'(11'h03F - 11'(i / 3)));
            end
            @(negedge clk_in);
        end
        byte_valid = 1'b0;
        check("t3_overrun_sticky", overrun, 1);

        // 4: restart after one byte
        pulse_frame_start();
        check("t4_overrun_clr", overrun, 0);
        base_wr = wr_count;
        send_byte(8'hAB);
        pulse_frame_start();
        send_byte(8'h12);
        send_byte(8'h34);
        @(negedge clk_in);
        check("t4_we",   ram_write_enable, 1);
        check("t4_addr", ram_address,      11'h03F);
        check("t4_data", ram_data_out,     16'h1234);
        repeat (2) @(negedge clk_in);
        check("t4_writes", wr_count - base_wr, 1);

        // 5: reset during SECOND
        pulse_frame_start();
        base_wr = wr_count;
        send_byte(8'h55);
        @(negedge clk_in);
        reset = 1'b1;
        @(negedge clk_in);
        check("t5_ready",   byte_ready,       0);
        check("t5_addr",    ram_address,      0);
        check("t5_data",    ram_data_out,     0);
        check("t5_we",      ram_write_enable, 0);
        check("t5_ce",      ram_clk_enable,   0);
        check("t5_done",    frame_done,       0);
        check("t5_overrun", overrun,          0);
        check("t5_rstpass", ram_reset,        1);
        reset = 1'b0;
        pulse_frame_start();
        send_byte(8'h66);
        send_byte(8'h77);
        @(negedge clk_in);
        check("t5_addr_first", ram_address,  11'h03F);
        check("t5_data_first", ram_data_out, 16'h6677);
        repeat (2) @(negedge clk_in);
        check("t5_writes", wr_count - base_wr, 1);
        check("t5_strobe_len", long_strobe, 0);

        // 6: bytes while IDLE, then low-byte-first packing
        @(negedge clk_in);
        reset = 1'b1;
        @(negedge clk_in);
        reset = 1'b0;
        base_wr = wr_count; base_b = b_wr_count;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            byte_in = 8'(8'hC0 + i);
            byte_valid = 1'b1;
        end
        @(negedge clk_in);
        byte_valid = 1'b0;
        repeat (2) @(negedge clk_in);
        check("t6_idle_writes",   wr_count - base_wr,  0);
        check("t6_idle_writes_b", b_wr_count - base_b, 0);
        check("t6_idle_overrun",   overrun,   0);
        check("t6_idle_overrun_b", b_overrun, 0);
        pulse_frame_start();
        send_byte(8'h34);
        send_byte(8'h12);
        @(negedge clk_in);
        check("t6_lo_we",   b_ram_write_enable, 1);
        check("t6_lo_data", b_ram_data_out,     16'h1234);
        check("t6_lo_addr", b_ram_address,      11'h03F);
        check("t6_hi_data", ram_data_out,       16'h3412);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
